// File: rtl/led_chaser_ctrl.sv
// Single-LED chaser: steps a one-hot LED across NUM_LEDS outputs every STEP_COUNT+1 clocks, wrap or bounce.
// Optional freeze input enabled by defining LED_CHASER_PAUSE_EN.
`timescale 1ns/1ps

module led_chaser_ctrl #(
    parameter int NUM_LEDS    = 5,
    parameter int COUNT_WIDTH = 32,
    parameter int STEP_COUNT  = 1500000 - 1
) (
    input  logic                clk,
    input  logic                rst_btn,
    input  logic                start,
    input  logic                stop,
    input  logic                mode,
    input  logic                pause,
    output logic [NUM_LEDS-1:0] led_en,
    output logic                busy,
    output logic                step_tick
);

    localparam int POS_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam logic [POS_W-1:0]       LAST_POS = POS_W'(NUM_LEDS - 1);
    localparam logic [POS_W-1:0]       PRE_LAST = POS_W'(NUM_LEDS - 2);
    localparam logic [POS_W-1:0]       ONE_POS  = POS_W'(1);
    localparam logic [COUNT_WIDTH-1:0] STEP_LIM = COUNT_WIDTH'(STEP_COUNT);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN_FWD = 2'd1,
        S_RUN_REV = 2'd2
    } state_t;

    state_t                  r_state;
    logic [COUNT_WIDTH-1:0]  r_count;
    logic [POS_W-1:0]        r_pos;
    logic                    r_mode;
    logic [NUM_LEDS-1:0]     r_led_en;
    logic                    r_busy;
    logic                    r_step_tick;

    state_t                  w_next_state;
    logic [POS_W-1:0]        w_next_pos;
    logic                    w_step_hit;
    logic                    w_freeze;

`ifdef LED_CHASER_PAUSE_EN
    assign w_freeze = pause;
`else
    logic w_unused_pause;
    assign w_unused_pause = pause;
    assign w_freeze       = 1'b0;
`endif

    function automatic logic [NUM_LEDS-1:0] f_onehot(input logic [POS_W-1:0] p);
        logic [NUM_LEDS-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            if (p == POS_W'(i)) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

    assign w_step_hit = (r_count == STEP_LIM);

    // Next position/direction, applied only on a step boundary
    always_comb begin
        w_next_state = r_state;
        w_next_pos   = r_pos;
        if (NUM_LEDS == 1) begin
            w_next_state = S_RUN_FWD;
            w_next_pos   = '0;
        end else if (!r_mode) begin
            w_next_state = S_RUN_FWD;
            w_next_pos   = (r_pos == LAST_POS) ? '0 : r_pos + 1'b1;
        end else if (r_state == S_RUN_REV) begin
            w_next_pos   = r_pos - 1'b1;
            w_next_state = (r_pos == ONE_POS) ? S_RUN_FWD : S_RUN_REV;
        end else begin
            w_next_pos   = r_pos + 1'b1;
            w_next_state = (r_pos == PRE_LAST) ? S_RUN_REV : S_RUN_FWD;
        end
    end

    always_ff @(posedge clk or negedge rst_btn) begin
        if (!rst_btn) begin
            r_state     <= S_IDLE;
            r_count     <= '0;
            r_pos       <= '0;
            r_mode      <= 1'b0;
            r_led_en    <= '0;
            r_busy      <= 1'b0;
            r_step_tick <= 1'b0;
        end else begin
            r_step_tick <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && !stop) begin
                        r_state  <= S_RUN_FWD;
                        r_count  <= '0;
                        r_pos    <= '0;
                        r_mode   <= mode;
                        r_led_en <= NUM_LEDS'(1);
                        r_busy   <= 1'b1;
                    end
                end
                S_RUN_FWD, S_RUN_REV: begin
                    if (stop) begin
                        r_state  <= S_IDLE;
                        r_count  <= '0;
                        r_pos    <= '0;
                        r_led_en <= '0;
                        r_busy   <= 1'b0;
                    end else if (!w_freeze) begin
                        if (w_step_hit) begin
                            r_count     <= '0;
                            r_pos       <= w_next_pos;
                            r_state     <= w_next_state;
                            r_led_en    <= f_onehot(w_next_pos);
                            r_step_tick <= 1'b1;
                        end else begin
                            r_count <= r_count + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_count  <= '0;
                    r_pos    <= '0;
                    r_led_en <= '0;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    assign led_en    = r_led_en;
    assign busy      = r_busy;
    assign step_tick = r_step_tick;

endmodule

// File: tb/tb_led_chaser_ctrl.sv
// Directed bench for led_chaser_ctrl: main instance (5 LEDs, step 3) plus step-0 and single-LED instances.
`timescale 1ns/1ps

module tb_led_chaser_ctrl;

    logic       clk     = 1'b0;
    logic       rst_btn = 1'b0;
    logic       start   = 1'b0;
    logic       stop    = 1'b0;
    logic       mode    = 1'b0;
    logic       pause   = 1'b0;

    logic [4:0] led_a, led_z;
    logic [0:0] led_o;
    logic       busy_a, tick_a, busy_z, tick_z, busy_o, tick_o;

    int n_chk = 0;
    int n_err = 0;
    int keff;

`ifdef LED_CHASER_PAUSE_EN
    localparam bit PAUSE_EN = 1'b1;
`else
    localparam bit PAUSE_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    led_chaser_ctrl #(.NUM_LEDS(5), .COUNT_WIDTH(32), .STEP_COUNT(3)) u_dut_a (
        .clk(clk), .rst_btn(rst_btn), .start(start), .stop(stop), .mode(mode), .pause(pause),
        .led_en(led_a), .busy(busy_a), .step_tick(tick_a)
    );

    led_chaser_ctrl #(.NUM_LEDS(5), .COUNT_WIDTH(8), .STEP_COUNT(0)) u_dut_z (
        .clk(clk), .rst_btn(rst_btn), .start(start), .stop(stop), .mode(mode), .pause(pause),
        .led_en(led_z), .busy(busy_z), .step_tick(tick_z)
    );

    led_chaser_ctrl #(.NUM_LEDS(1), .COUNT_WIDTH(8), .STEP_COUNT(3)) u_dut_o (
        .clk(clk), .rst_btn(rst_btn), .start(start), .stop(stop), .mode(mode), .pause(pause),
        .led_en(led_o), .busy(busy_o), .step_tick(tick_o)
    );

    function automatic logic [31:0] pk(input logic b, input logic t, input logic [4:0] l);
        return {23'd0, b, t, 2'b00, l};
    endfunction

    // Expected {busy, step_tick, led_en} k cycles after the start was accepted
    function automatic logic [31:0] exp_run(input int k, input int per, input bit bnc, input int nleds);
        int         idx;
        logic [4:0] l;
        idx = k / per;
        if (nleds == 1) begin
            l = 5'd1;
        end else if (bnc) begin
            case (idx % 8)
                0:       l = 5'b00001;
                1:       l = 5'b00010;
                2:       l = 5'b00100;
                3:       l = 5'b01000;
                4:       l = 5'b10000;
                5:       l = 5'b01000;
                6:       l = 5'b00100;
                default: l = 5'b00010;
            endcase
        end else begin
            l = 5'd1 << (idx % 5);
        end
        return pk(1'b1, (k > 0) && (k % per == 0), l);
    endfunction

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step_clk(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_idle(input string tag);
        check_val({tag, "_a"}, pk(busy_a, tick_a, led_a), 32'd0);
        check_val({tag, "_z"}, pk(busy_z, tick_z, led_z), 32'd0);
        check_val({tag, "_o"}, pk(busy_o, tick_o, {4'd0, led_o}), 32'd0);
    endtask

    initial begin
        rst_btn = 1'b0;
        step_clk(3);
        chk_idle("reset");
        rst_btn = 1'b1;
        step_clk(7);

        // Wrap run; a start with mode=1 mid-run must be ignored
        start = 1'b1;
        mode  = 1'b0;
        step_clk(1);
        for (int k = 0; k <= 45; k++) begin
            check_val($sformatf("wrap_a k=%0d", k), pk(busy_a, tick_a, led_a), exp_run(k, 4, 1'b0, 5));
            check_val($sformatf("wrap_z k=%0d", k), pk(busy_z, tick_z, led_z), exp_run(k, 1, 1'b0, 5));
            check_val($sformatf("wrap_o k=%0d", k), pk(busy_o, tick_o, {4'd0, led_o}), exp_run(k, 4, 1'b0, 1));
            if (k == 23) begin
                start = 1'b1;
                mode  = 1'b1;
            end else begin
                start = 1'b0;
                mode  = 1'b0;
            end
            step_clk(1);
        end

        stop = 1'b1;
        step_clk(1);
        stop = 1'b0;
        chk_idle("stop");
        step_clk(4);
        chk_idle("stop_hold");

        start = 1'b1;
        stop  = 1'b1;
        step_clk(1);
        start = 1'b0;
        stop  = 1'b0;
        chk_idle("contend");
        step_clk(4);
        chk_idle("contend_hold");

        // Bounce run; mode is dropped after the start to confirm it was latched
        start = 1'b1;
        mode  = 1'b1;
        step_clk(1);
        start = 1'b0;
        mode  = 1'b0;
        for (int k = 0; k <= 39; k++) begin
            check_val($sformatf("bnc_a k=%0d", k), pk(busy_a, tick_a, led_a), exp_run(k, 4, 1'b1, 5));
            check_val($sformatf("bnc_z k=%0d", k), pk(busy_z, tick_z, led_z), exp_run(k, 1, 1'b1, 5));
            check_val($sformatf("bnc_o k=%0d", k), pk(busy_o, tick_o, {4'd0, led_o}), exp_run(k, 4, 1'b1, 1));
            step_clk(1);
        end

        // Asynchronous reset between edges
        #3;
        rst_btn = 1'b0;
        #1;
        chk_idle("async");
        @(posedge clk);
        #1;
        chk_idle("async_edge");
        #3;
        rst_btn = 1'b1;
        step_clk(3);
        chk_idle("post_rst");

        // Pause at counter=2 for 10 cycles
        keff  = 0;
        start = 1'b1;
        mode  = 1'b0;
        step_clk(1);
        start = 1'b0;
        check_val("pause_pre k=0", pk(busy_a, tick_a, led_a), exp_run(keff, 4, 1'b0, 5));
        for (int i = 0; i < 2; i++) begin
            step_clk(1);
            keff++;
            check_val($sformatf("pause_pre k=%0d", keff), pk(busy_a, tick_a, led_a), exp_run(keff, 4, 1'b0, 5));
        end
        pause = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step_clk(1);
            if (!PAUSE_EN) keff++;
            check_val($sformatf("pause_hold i=%0d", i), pk(busy_a, tick_a, led_a), exp_run(keff, 4, 1'b0, 5));
        end
        pause = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step_clk(1);
            keff++;
            check_val($sformatf("pause_rel i=%0d", i), pk(busy_a, tick_a, led_a), exp_run(keff, 4, 1'b0, 5));
        end

        pause = 1'b1;
        stop  = 1'b1;
        step_clk(1);
        pause = 1'b0;
        stop  = 1'b0;
        chk_idle("stop_pause");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
